// File: rtl/if_instr_mem.sv
// ---------------------------------------------------------------------------
// if_instr_mem
// IF-stage instruction memory. The debug unit first streams the program in
// byte-by-byte (MSB of each word first). After the transfer ends, the block
// fetches one word per enabled cycle from the byte address produced by
// p_counter and registers it for the IF/ID stage. A fetched HALT opcode
// freezes the block until reset.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_enable       global run enable (debug step / continuous)
//   i_stall        hazard stall: hold the fetched word
//   i_PC           byte address from p_counter
//   i_load_valid   one-cycle strobe, i_load_byte is valid
//   i_load_byte    program byte, MSB of each word first
//   i_load_done    one-cycle strobe, program transfer complete
//   o_instruction  fetched instruction (registered, 1-cycle latency)
//   o_halt         HALT fetched; sticky until reset
//   o_ready        program loaded and fetch active
//   o_load_full    every memory word has been written
//   o_load_count   words written so far (saturates at N_WORDS)
// ---------------------------------------------------------------------------
module if_instr_mem #(
  parameter int         N_WORDS     = 64,
  parameter int         ADDR_W      = 6,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic [31:0]       i_PC,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  input  logic              i_load_done,
  output logic [31:0]       o_instruction,
  output logic              o_halt,
  output logic              o_ready,
  output logic              o_load_full,
  output logic [ADDR_W:0]   o_load_count
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALTED} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(N_WORDS);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(N_WORDS - 1);

  state_t            state, state_next;
  logic [31:0]       mem [N_WORDS];

  // Up to three pending bytes of the word being assembled, oldest highest.
  logic [23:0]       asm_word;
  logic [31:0]       asm_next;
  logic [1:0]        byte_cnt, byte_cnt_next;
  logic [2:0]        cnt_after;
  logic [ADDR_W:0]   wptr;
  logic              accept_byte;
  logic              wr_en;
  logic [31:0]       wr_data;

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_hit;
  logic [31:0]       rd_data;
  logic              fetch_en;
  logic              fetch_halt;
  logic              unused_pc_bits;

  // Byte lanes within a word are irrelevant to an instruction fetch.
  assign unused_pc_bits = ^i_PC[1:0];

  // -------------------------------------------------------------------------
  // Load path: the incoming byte is accepted first, then a same-cycle done
  // flushes whatever partial word remains (zero-padded in its low bytes).
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    accept_byte   = (state == S_LOAD) && i_load_valid;
    asm_next      = accept_byte ? {asm_word, i_load_byte} : {8'h00, asm_word};
    cnt_after     = {1'b0, byte_cnt} + {2'b00, accept_byte};
    byte_cnt_next = cnt_after[1:0];
    wr_en         = 1'b0;
    wr_data       = asm_next;
    if (cnt_after == 3'd4) begin
      wr_en = 1'b1;
    end else if ((state == S_LOAD) && i_load_done && (cnt_after != 3'd0)) begin
      wr_en         = 1'b1;
      byte_cnt_next = 2'd0;
      case (cnt_after[1:0])
        2'd1:    wr_data = {asm_next[7:0],  24'h000000};
        2'd2:    wr_data = {asm_next[15:0], 16'h0000};
        default: wr_data = {asm_next[23:0], 8'h00};
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Fetch path: words never written in this load session (index >= wptr) and
  // addresses beyond the array read as NOP, hiding stale contents.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_idx     = i_PC[ADDR_W+1:2];
    rd_hit     = (i_PC[31:ADDR_W+2] == '0) && ({1'b0, rd_idx} < wptr);
    rd_data    = rd_hit ? mem[rd_idx] : 32'h0;
    fetch_en   = (state == S_RUN) && i_enable && !i_stall;
    fetch_halt = fetch_en && (rd_data[31:26] == HALT_OPCODE);
  end

  // -------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    if (i_reset) state <= S_LOAD;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:   if ((wr_en && (wptr == LAST_CNT)) || i_load_done) state_next = S_RUN;
      S_RUN:    if (fetch_halt) state_next = S_HALTED;
      default:  state_next = state;
    endcase
  end

  always_comb begin
    o_ready      = (state != S_LOAD);
    o_load_full  = (wptr == FULL_CNT);
    o_load_count = wptr;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      byte_cnt      <= 2'd0;
      asm_word      <= 24'h0;
      wptr          <= '0;
      o_instruction <= 32'h0;
      o_halt        <= 1'b0;
    end else begin
      byte_cnt <= byte_cnt_next;
      asm_word <= asm_next[23:0];
      if (wr_en)      wptr          <= wptr + 1'b1;
      if (fetch_en)   o_instruction <= rd_data;
      if (fetch_halt) o_halt        <= 1'b1;
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; contents left
  // from an earlier program are masked by wptr on the read side instead.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset) mem[wptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule
